// File: rtl/m_sequence_checker_pkg.sv
// Shared definitions for the PRBS sequence checker: default polynomial and FSM states.
// The defaults mirror the transmitter so both ends agree on the polynomial.
package m_sequence_checker_pkg;

    localparam int               ORDER_DEF       = 7;
    localparam logic [6:0]       TAPS_DEF        = 7'b1100000;
    localparam int               LOCK_COUNT_DEF  = 16;
    localparam int               WINDOW_DEF      = 64;
    localparam int               LOSS_THRESH_DEF = 8;
    localparam int               CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/m_sequence_checker_if.sv
// Serial-bit input and BER status bundle between a bitstream source and the checker.
interface m_sequence_checker_if #(
    parameter int CNT_W = 16
);
    logic             data_valid;
    logic             data_i;
    logic             clear;
    logic             locked;
    logic             bit_error;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output data_valid, data_i, clear,
        input  locked, bit_error, bit_count, err_count
    );

    modport slave (
        input  data_valid, data_i, clear,
        output locked, bit_error, bit_count, err_count
    );
endinterface

// File: rtl/m_sequence_checker_predictor.sv
// Combinational LFSR step: predicted next bit plus the two candidate next shift-register values.
module m_sequence_predictor #(
    parameter int               ORDER = 7,
    parameter logic [ORDER-1:0] TAPS  = 7'b1100000
) (
    input  logic [ORDER-1:0] i_sr,
    input  logic             i_bit,
    output logic             o_expected,
    output logic [ORDER-1:0] o_sr_exp,
    output logic [ORDER-1:0] o_sr_in
);
    assign o_expected = ^(i_sr & TAPS);
    assign o_sr_exp   = {i_sr[ORDER-2:0], o_expected};
    assign o_sr_in    = {i_sr[ORDER-2:0], i_bit};
endmodule

// File: rtl/m_sequence_checker.sv
// Self-synchronising PRBS checker: hunts for sequence phase, verifies, locks,
// then counts checked bits and bit errors, dropping lock on dense errors.
module m_sequence_checker
    import m_sequence_checker_pkg::*;
#(
    parameter int               ORDER       = ORDER_DEF,
    parameter logic [ORDER-1:0] TAPS        = TAPS_DEF,
    parameter int               LOCK_COUNT  = LOCK_COUNT_DEF,
    parameter int               WINDOW      = WINDOW_DEF,
    parameter int               LOSS_THRESH = LOSS_THRESH_DEF,
    parameter int               CNT_W       = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    m_sequence_checker_if.slave  bus
);
    localparam int FILL_W  = $clog2(ORDER + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WBITS_W = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(ORDER - 1);
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(ORDER);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [WBITS_W-1:0] WBITS_LAST = WBITS_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THRESH - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             r_state;
    logic [ORDER-1:0]   r_sr;
    logic [FILL_W-1:0]  r_fill;
    logic [MATCH_W-1:0] r_match;
    logic [WBITS_W-1:0] r_wbits;
    logic [WERR_W-1:0]  r_werrs;
    logic [CNT_W-1:0]   r_bit_count;
    logic [CNT_W-1:0]   r_err_count;
    logic               r_locked;
    logic               r_bit_error;

    logic               w_expected;
    logic [ORDER-1:0]   w_sr_exp;
    logic [ORDER-1:0]   w_sr_in;
    logic               w_mismatch;

    m_sequence_predictor #(
        .ORDER (ORDER),
        .TAPS  (TAPS)
    ) u_predictor (
        .i_sr       (r_sr),
        .i_bit      (bus.data_i),
        .o_expected (w_expected),
        .o_sr_exp   (w_sr_exp),
        .o_sr_in    (w_sr_in)
    );

    assign w_mismatch = bus.data_i ^ w_expected;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_sr        <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_wbits     <= '0;
            r_werrs     <= '0;
            r_bit_count <= '0;
            r_err_count <= '0;
            r_locked    <= 1'b0;
            r_bit_error <= 1'b0;
        end else begin
            r_bit_error <= 1'b0;
            if (bus.data_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        r_sr <= w_sr_in;
                        if (r_fill != FILL_FULL)
                            r_fill <= r_fill + FILL_W'(1);
                        // An all-zero register would predict zeros forever, so never verify from it.
                        if ((r_fill >= FILL_LAST) && (w_sr_in != '0)) begin
                            r_state <= ST_VERIFY;
                            r_match <= '0;
                        end
                    end
                    ST_VERIFY: begin
                        if (!w_mismatch) begin
                            r_sr <= w_sr_exp;
                            if (r_match == MATCH_LAST) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                                r_wbits  <= '0;
                                r_werrs  <= '0;
                            end else begin
                                r_match <= r_match + MATCH_W'(1);
                            end
                        end else begin
                            r_state <= ST_HUNT;
                            r_fill  <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Regenerate from the prediction only, so a received error never enters sr.
                        r_sr        <= w_sr_exp;
                        r_bit_count <= sat_inc(r_bit_count);
                        if (w_mismatch) begin
                            r_err_count <= sat_inc(r_err_count);
                            r_bit_error <= 1'b1;
                        end
                        if (w_mismatch && (r_werrs == WERR_LAST)) begin
                            r_state  <= ST_HUNT;
                            r_locked <= 1'b0;
                            r_fill   <= '0;
                            r_match  <= '0;
                        end else if (r_wbits == WBITS_LAST) begin
                            r_wbits <= '0;
                            r_werrs <= '0;
                        end else begin
                            r_wbits <= r_wbits + WBITS_W'(1);
                            r_werrs <= r_werrs + WERR_W'(w_mismatch);
                        end
                    end
                    default: begin
                        r_state  <= ST_HUNT;
                        r_locked <= 1'b0;
                        r_fill   <= '0;
                    end
                endcase
            end
            // Clear is issued after the increments so it wins on the same cycle.
            if (bus.clear) begin
                r_bit_count <= '0;
                r_err_count <= '0;
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.bit_error = r_bit_error;
    assign bus.bit_count = r_bit_count;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_m_sequence_checker.sv
// Directed bench for m_sequence_checker: lock, sparse errors, loss/relock, all-zero input,
// clear vs error, and saturation in a narrow-counter build.
module tb_m_sequence_checker;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [6:0] gsr;
    localparam logic [6:0] TAPS = 7'b1100000;

    m_sequence_checker_if #(.CNT_W(16)) bus  ();
    m_sequence_checker_if #(.CNT_W(4))  bus4 ();

    m_sequence_checker #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    m_sequence_checker #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic dv, input logic d, input logic clr);
        bus.data_valid  = dv;
        bus.data_i      = d;
        bus.clear       = clr;
        bus4.data_valid = dv;
        bus4.data_i     = d;
        bus4.clear      = clr;
    endtask

    // One valid bit, then three idle clocks; bit_error is sampled in the cycle after the bit.
    task automatic send_bit(input logic b, input logic clr, output logic be);
        @(negedge clk);
        drive(1'b1, b, clr);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        be = bus.bit_error;
        repeat (2) @(negedge clk);
    endtask

    task automatic next_prbs(output logic b);
        b   = ^(gsr & TAPS);
        gsr = {gsr[5:0], b};
    endtask

    task automatic send_prbs(input logic flip, input logic clr, output logic be);
        logic b;
        next_prbs(b);
        send_bit(b ^ flip, clr, be);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic lock_up();
        logic be;
        repeat (23) send_prbs(1'b0, 1'b0, be);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.locked, bus.bit_error, bus.bit_count, bus.err_count} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got locked=%0b be=%0b bc=%0d ec=%0d, expected all 0",
                     bus.locked, bus.bit_error, bus.bit_count, bus.err_count);
        end
        checks++;
        if ({bus4.locked, bus4.bit_error, bus4.bit_count, bus4.err_count} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs_w4: got locked=%0b bc=%0d ec=%0d, expected all 0",
                     bus4.locked, bus4.bit_count, bus4.err_count);
        end
    endtask

    task automatic test_lock();
        logic be;
        int   pulses;
        pulses = 0;
        do_reset();
        for (int i = 1; i <= 23; i++) begin
            send_prbs(1'b0, 1'b0, be);
            if (i == 22) begin
                checks++;
                if (bus.locked !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_early: locked=%0b after 22 bits, expected 0", bus.locked);
                end
            end
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_at_23: locked=%0b after 23 bits, expected 1", bus.locked);
        end
        for (int i = 0; i < 1000; i++) begin
            send_prbs(1'b0, 1'b0, be);
            if (be === 1'b1) pulses++;
        end
        checks++;
        if (bus.bit_count !== 16'd1000) begin
            errors++;
            $display("FAIL clean_bit_count: got %0d, expected 1000", bus.bit_count);
        end
        checks++;
        if (bus.err_count !== 16'd0 || pulses != 0) begin
            errors++;
            $display("FAIL clean_errors: err_count=%0d pulses=%0d, expected 0/0", bus.err_count, pulses);
        end
    endtask

    task automatic test_sparse_errors();
        logic be;
        int   pulses;
        pulses = 0;
        for (int i = 0; i < 320; i++) begin
            send_prbs((i % 32) == 31, 1'b0, be);
            if (be === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL sparse_pulses: got %0d, expected 10", pulses);
        end
        checks++;
        if (bus.err_count !== 16'd10) begin
            errors++;
            $display("FAIL sparse_err_count: got %0d, expected 10", bus.err_count);
        end
        checks++;
        if (bus.locked !== 1'b1 || bus.bit_count !== 16'd1320) begin
            errors++;
            $display("FAIL sparse_lock_hold: locked=%0b bc=%0d, expected 1/1320", bus.locked, bus.bit_count);
        end
    endtask

    task automatic test_loss_relock();
        logic be;
        do_reset();
        lock_up();
        for (int k = 0; k < 8; k++) begin
            send_prbs(1'b1, 1'b0, be);
            if (k == 6) begin
                checks++;
                if (bus.locked !== 1'b1) begin
                    errors++;
                    $display("FAIL loss_after_7: locked=%0b, expected 1", bus.locked);
                end
            end
        end
        checks++;
        if (bus.locked !== 1'b0 || bus.err_count !== 16'd8) begin
            errors++;
            $display("FAIL loss_after_8: locked=%0b ec=%0d, expected 0/8", bus.locked, bus.err_count);
        end
        for (int i = 1; i <= 23; i++) begin
            send_prbs(1'b0, 1'b0, be);
            if (i == 22) begin
                checks++;
                if (bus.locked !== 1'b0) begin
                    errors++;
                    $display("FAIL relock_early: locked=%0b after 22 bits, expected 0", bus.locked);
                end
            end
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL relock_at_23: locked=%0b, expected 1", bus.locked);
        end
    endtask

    task automatic test_all_zero();
        logic be;
        int   seen_lock;
        seen_lock = 0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            send_bit(1'b0, 1'b0, be);
            if (bus.locked !== 1'b0 || be !== 1'b0) seen_lock++;
        end
        checks++;
        if (seen_lock != 0) begin
            errors++;
            $display("FAIL zero_no_lock: %0d bits with lock/error seen, expected 0", seen_lock);
        end
        checks++;
        if (bus.bit_count !== 16'd0 || bus.err_count !== 16'd0) begin
            errors++;
            $display("FAIL zero_counters: bc=%0d ec=%0d, expected 0/0", bus.bit_count, bus.err_count);
        end
    endtask

    task automatic test_clear_on_error();
        logic be;
        do_reset();
        lock_up();
        repeat (10) send_prbs(1'b0, 1'b0, be);
        send_prbs(1'b1, 1'b1, be);
        checks++;
        if (be !== 1'b1 || bus.err_count !== 16'd0 || bus.bit_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_vs_error: be=%0b ec=%0d bc=%0d, expected 1/0/0", be, bus.err_count, bus.bit_count);
        end
        send_prbs(1'b0, 1'b0, be);
        checks++;
        if (bus.bit_count !== 16'd1 || bus.err_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_resume: bc=%0d ec=%0d, expected 1/0", bus.bit_count, bus.err_count);
        end
        send_prbs(1'b1, 1'b0, be);
        checks++;
        if (be !== 1'b1 || bus.bit_count !== 16'd2 || bus.err_count !== 16'd1) begin
            errors++;
            $display("FAIL clear_err_resume: be=%0b bc=%0d ec=%0d, expected 1/2/1", be, bus.bit_count, bus.err_count);
        end
    endtask

    task automatic test_saturation_and_reset();
        logic be;
        do_reset();
        lock_up();
        repeat (20) send_prbs(1'b0, 1'b0, be);
        checks++;
        if (bus4.bit_count !== 4'd15 || bus.bit_count !== 16'd20) begin
            errors++;
            $display("FAIL saturate: w4 bc=%0d w16 bc=%0d, expected 15/20", bus4.bit_count, bus.bit_count);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus4.locked, bus4.bit_error, bus4.bit_count, bus4.err_count} !== 10'd0 ||
            {bus.locked, bus.bit_error, bus.bit_count, bus.err_count} !== 34'd0) begin
            errors++;
            $display("FAIL mid_reset: w4 lk=%0b bc=%0d w16 lk=%0b bc=%0d, expected all 0",
                     bus4.locked, bus4.bit_count, bus.locked, bus.bit_count);
        end
        for (int i = 1; i <= 23; i++) begin
            send_prbs(1'b0, 1'b0, be);
            if (i == 22) begin
                checks++;
                if (bus4.locked !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_hunt: locked=%0b after 22 bits, expected 0", bus4.locked);
                end
            end
        end
        checks++;
        if (bus4.locked !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_relock: locked=%0b after 23 bits, expected 1", bus4.locked);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        gsr    = 7'h5A;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        test_reset();
        test_lock();
        test_sparse_errors();
        test_loss_relock();
        test_all_zero();
        test_clear_on_error();
        test_saturation_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
